// File: rtl/hex_time_reader.sv
// Decodes the reaction-timer seven-segment display, waits for it to freeze and reports mm:ss.cc as centiseconds.
// Optional build macro BEST_TIME_EN adds the best_cs port tracking the lowest reported time.
module hex_time_reader #(
    parameter int unsigned STABLE_CYCLES = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [6:0]  HEX0,
    input  logic [6:0]  HEX1,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX5,
    output logic        result_valid,
    output logic [18:0] time_cs,
    output logic        running,
    output logic        decode_err
`ifdef BEST_TIME_EN
    ,
    output logic [18:0] best_cs
`endif
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BLANK, S_ZERO, S_RUN, S_SETTLE, S_CONV1, S_CONV2, S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [41:0]    r_s0;
    logic [41:0]    r_s1;
    logic [CW-1:0]  r_cnt;
    logic           r_reported;
    logic [6:0]     r_mm;
    logic [6:0]     r_ss;
    logic [6:0]     r_cc;
    logic [18:0]    r_calc;
    logic [5:0]     w_code [6];
    logic [3:0]     w_dig [6];
    logic           w_legal_all;
    logic           w_any_blank;
    logic           w_all_zero;
    logic           w_illegal;
    logic           w_change;
    logic           w_strobe;

    // {legal, blank, digit}; blank and illegal patterns decode to digit 0
    function automatic logic [5:0] f_dec(input logic [6:0] seg);
        case (seg)
            7'b1000000: f_dec = {2'b10, 4'd0};
            7'b1111001: f_dec = {2'b10, 4'd1};
            7'b0100100: f_dec = {2'b10, 4'd2};
            7'b0110000: f_dec = {2'b10, 4'd3};
            7'b0011001: f_dec = {2'b10, 4'd4};
            7'b0010010: f_dec = {2'b10, 4'd5};
            7'b0000011: f_dec = {2'b10, 4'd6};
            7'b1111000: f_dec = {2'b10, 4'd7};
            7'b0000000: f_dec = {2'b10, 4'd8};
            7'b0011000: f_dec = {2'b10, 4'd9};
            7'b1111111: f_dec = {2'b11, 4'd0};
            default:    f_dec = {2'b00, 4'd0};
        endcase
    endfunction

    always_comb begin
        w_legal_all = 1'b1;
        w_any_blank = 1'b0;
        w_all_zero  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_code[i]   = f_dec(r_s0[7*i +: 7]);
            w_dig[i]    = w_code[i][3:0];
            w_legal_all = w_legal_all & w_code[i][5];
            w_any_blank = w_any_blank | w_code[i][4];
            w_all_zero  = w_all_zero & w_code[i][5] & ~w_code[i][4] & (w_code[i][3:0] == 4'd0);
        end
        w_illegal = ~w_legal_all | (w_dig[3] > 4'd5) | (w_dig[5] > 4'd5);
        w_change  = (r_s0 != r_s1);
    end

    always_comb begin
        w_next_state = r_state;
        w_strobe     = 1'b0;
        if (w_illegal || w_any_blank) begin
            w_next_state = S_BLANK;
        end else begin
            case (r_state)
                S_BLANK:  w_next_state = w_all_zero ? S_ZERO : S_RUN;
                S_ZERO:   if (w_change) w_next_state = S_RUN;
                S_RUN:    if (!w_change) w_next_state = S_SETTLE;
                S_SETTLE: begin
                    if (w_change)
                        w_next_state = S_RUN;
                    else if (r_cnt == CNT_LAST && !r_reported)
                        w_next_state = S_CONV1;
                end
                S_CONV1:  w_next_state = w_change ? S_RUN : S_CONV2;
                S_CONV2: begin
                    if (w_change) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_HOLD;
                        w_strobe     = 1'b1;
                    end
                end
                S_HOLD:   if (w_change) w_next_state = S_RUN;
                default:  w_next_state = S_BLANK;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_BLANK;
            r_s0         <= '1;
            r_s1         <= '1;
            r_cnt        <= '0;
            r_reported   <= 1'b0;
            r_mm         <= '0;
            r_ss         <= '0;
            r_cc         <= '0;
            r_calc       <= '0;
            result_valid <= 1'b0;
            time_cs      <= '0;
            running      <= 1'b0;
            decode_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_s0         <= {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
            r_s1         <= r_s0;
            result_valid <= w_strobe;
            running      <= (w_next_state == S_RUN);
            decode_err   <= decode_err | w_illegal;

            // Cycles since the last display change, saturating at the window end
            if (w_change)
                r_cnt <= '0;
            else if (r_cnt != CNT_LAST)
                r_cnt <= r_cnt + CW'(1);

            if (r_state == S_BLANK || (r_state == S_HOLD && w_next_state == S_RUN))
                r_reported <= 1'b0;
            else if (w_strobe)
                r_reported <= 1'b1;

            if (w_next_state == S_CONV1) begin
                r_mm <= 7'(w_dig[5]) * 7'd10 + 7'(w_dig[4]);
                r_ss <= 7'(w_dig[3]) * 7'd10 + 7'(w_dig[2]);
                r_cc <= 7'(w_dig[1]) * 7'd10 + 7'(w_dig[0]);
            end
            if (r_state == S_CONV1)
                r_calc <= (19'(r_mm) * 19'd60 + 19'(r_ss)) * 19'd100 + 19'(r_cc);
            if (w_strobe)
                time_cs <= r_calc;
        end
    end

`ifdef BEST_TIME_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            best_cs <= 19'h7FFFF;
        else if (w_strobe && r_calc < best_cs)
            best_cs <= r_calc;
    end
`endif

endmodule

// File: doc/hex_time_reader.md
# hex_time_reader

Recovers the reaction-time result from the six active-low seven-segment buses HEX0–HEX5 driven by the reaction-timer game. It decodes each pattern back to a BCD digit, detects when the running display has frozen, converts mm:ss.cc to a binary centisecond count, and emits a one-cycle result strobe. It is a passive listener on the display buses and serves as the on-chip scorekeeper and verification monitor for the game.

## Interface
- STABLE_CYCLES, 2500000: consecutive unchanged cycles (50 ms at 50 MHz) before a frozen display counts as a result.
- CLOCK_50  input  1  sole clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high.
- HEX0..HEX5  input  7 each  active-low segment patterns. HEX0 is hundredths, HEX1 tenths, HEX2 seconds, HEX3 tens of seconds, HEX4 minutes, HEX5 tens of minutes.
- result_valid  output  1  one-cycle pulse; time_cs is valid while it is high.
- time_cs  output  19  reaction time in centiseconds (0..359999), held until the next result.
- running  output  1  high while the display is counting.
- decode_err  output  1  sticky; set when any digit pattern is illegal.
- best_cs  output  19  lowest reported time (present only with BEST_TIME_EN).

## Operation
- Decode table, per digit. Any other pattern is illegal.
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000011
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0011000
  - blank = 1111111
- HEX inputs are registered once (stage S0). Decode is combinational from S0. Change detection compares S0 with the previous S0 value (S1).
- Range checks: HEX3 digit > 5 or HEX5 digit > 5 is illegal.
- State machine:
  - BLANK: any digit is blank. Clears `reported`. Leave to ZERO or RUN when all six digits are legal and non-blank.
  - ZERO: all digits are 0; the game has just started counting. Go to RUN on the first change. Go to BLANK if any digit blanks.
  - RUN: display is changing; `running`=1. Every change reloads the stability counter to 0. Go to SETTLE when a cycle passes with no change.
  - SETTLE: counter increments each unchanged cycle.
    - Any change: back to RUN.
    - Any blank: BLANK.
    - Counter reaches STABLE_CYCLES-1 with `reported`=0: go to CONV.
  - CONV: two-stage multiply-add.
    - Stage 1: mm = 10·HEX5 + HEX4; ss = 10·HEX3 + HEX2; cc = 10·HEX1 + HEX0.
    - Stage 2: time_cs = (mm·60 + ss)·100 + cc.
    - Then pulse result_valid, set `reported`=1, and go to HOLD.
  - HOLD: frozen display already reported, so no repeat strobe. A change goes to RUN and clears `reported`. A blank goes to BLANK.
- A frozen all-zero display never reports; it stays in ZERO.
- An illegal pattern sets decode_err and forces state BLANK. decode_err clears only on reset.
- Arithmetic is unsigned with 19-bit intermediates; no overflow is possible within legal ranges.

## Timing
- Reset values:
  - state BLANK
  - result_valid 0
  - time_cs 0
  - running 0
  - decode_err 0
  - best_cs 19'h7FFFF
  - stability counter 0
  - S0 and S1 all ones (blank)
- Pin change to decode: 1 cycle (S0 register).
- From the last display change, result_valid rises STABLE_CYCLES + 3 cycles later (S0, stability window, two CONV stages).
- Stability counter width is clog2(STABLE_CYCLES). It saturates and never wraps.
- Simultaneous change and counter terminal count: the change wins, and the state returns to RUN.
- Reset asserted mid-CONV: the result is discarded and no strobe is issued.
- Display rollover at 59:59.99 to 00:00.00 is a change, so the state returns to RUN, not ZERO.

## Configuration
- BEST_TIME_EN defined:
  - best_cs port exists.
  - On each result_valid, best_cs is loaded with time_cs if time_cs < best_cs, in the same cycle as the strobe.
  - Reset restores 19'h7FFFF.
- Undefined: the best_cs port and its register are omitted entirely.

## Test plan
- Reset, then drive all HEX blank for 100 cycles -> state BLANK, result_valid never pulses, decode_err = 0.
- Use STABLE_CYCLES = 8. Drive zeros, step the display through a count, then freeze at 00:01.27 -> exactly one result_valid pulse 11 cycles after the freeze, with time_cs = 127.
- Freeze at 05:43.21 and hold for 1000 cycles -> exactly one strobe with time_cs = 34321; no repeat strobe.
- Drive HEX1 = 7'b0101010 for one cycle -> decode_err = 1 and stays 1; state BLANK.
- Freeze for 5 cycles, change one digit, then freeze -> no strobe at the first freeze; one strobe after the second.
- With BEST_TIME_EN: report 250, then 120, then 300 -> best_cs reads 250, then 120, then 120.
